biquad8_pole_coeff_loader: RTL and testbench
============================================

Name: biquad8_pole_coeff_loader

Overview:
- Host-side initiator for the pole-FIR coefficient port: coeff_adr/coeff_wr/coeff_dat/coeff_update.
- Host writes up to 17 coefficients into a staging bank, then pulses go. The block snapshots the bank and replays it into the DSP B-cascade chains in the only order that lands each value in its DSP. It then issues one update pulse so every B2 register switches at once.
- Sits between the register bus and the dual-biquad pole section.

Parameters:
- FLEN, 7, F-chain cascade DSPs (slots 0..FLEN-1); the F cross-link DSP is slot FLEN.
- GLEN, 8, G-chain cascade DSPs (slots 16..16+GLEN-1); the G cross-link DSP is slot 16+GLEN.
- CBITS, 18, coefficient width (Q4.14).
- HOLD, 3, cycles each write is held on the port. Must be >=3, because the consumer samples address at +1 and data at +2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- host_adr_i, in, 5, staging slot address (0..FLEN, 16..16+GLEN valid).
- host_dat_i, in, CBITS, staging data.
- host_wr_i, in, 1, staging write strobe.
- go_i, in, 1, start a load sequence.
- coeff_adr_o, out, 5, chain address to the pole FIR.
- coeff_wr_o, out, 1, coefficient write strobe.
- coeff_dat_o, out, CBITS, coefficient data.
- coeff_update_o, out, 1, B2 update pulse.
- busy_o, out, 1, load sequence in progress.
- done_o, out, 1, one-cycle completion pulse.

Behaviour:
- Reset (async, any time): all outputs are 0, the FSM goes to IDLE, and staging and working banks clear to 0.
  - Reset mid-sequence issues no update pulse. The consumer's B2 registers keep their old coefficients; B1 contents are don't-care.
- Staging bank: host_wr_i writes host_dat_i to the addressed slot.
  - Invalid addresses are silently dropped.
  - Staging writes are accepted in every state and affect only the next load.
- go_i while busy_o=1 is ignored.
- go_i in IDLE (edge E0):
  - Working bank is copied from staging. A host write in the same cycle as go is NOT included.
  - busy_o=1 from E0.
  - FSM enters WRITE.
- All port outputs are registered.
- WRITE: 17 write slots k=0..16, in this fixed order:
  - F cross: adr=FLEN, dat=slot FLEN.
  - F chain: adr=FLEN-1, dat=slot FLEN-1 down to slot 0 (7 writes).
  - G cross: adr=16+GLEN, dat=slot 16+GLEN.
  - G chain: adr=16+GLEN-1, dat=slot 16+GLEN-1 down to slot 16 (8 writes).
- Write k timing:
  - coeff_wr_o=1 in cycle 1+HOLD*k only.
  - coeff_adr_o and coeff_dat_o are held constant for HOLD cycles starting that cycle.
- Why this order works:
  - The cross DSP loads on any address >= its index, so it is written first; the junk it pushes into the cascade is flushed by the full-length chain shifts that follow.
  - The chain writes use address = last cascade index, so every cascade DSP shifts each time.
- UPDATE: the cycle after the last hold cycle (1+HOLD*17; cycle 52 at HOLD=3) has coeff_update_o=1 for exactly one cycle. coeff_wr_o=0.
- DONE: the next cycle (53 at HOLD=3) has done_o=1, busy_o=0, and the FSM returns to IDLE. A go_i in the DONE cycle is accepted.
- Between writes, coeff_wr_o=0. In IDLE, coeff_adr_o, coeff_dat_o and coeff_update_o are 0.
- Internal counters: slot counter 0..16 and hold counter 0..HOLD-1. Neither wraps beyond its terminal value.

Test Plan:
- Distinct values staged, slot s = 0x100+s, then go:
  - 17 wr pulses exactly 3 cycles apart.
  - adr sequence: 7, 6×7, 24, 23×8.
  - dat sequence: 0x107, 0x106..0x100, 0x118, 0x117..0x110.
  - Update at cycle 52, done at cycle 53.
- Bench model of the pole-FIR B1/B2 chains (2-cycle ceb1 latency, cascade shift on addr>=index): after done, DSP i holds 0x100+i, fdsp holds 0x107, gdsp holds 0x118.
- Staging write to slot 3 in the go cycle, plus writes during busy: the load uses the old value. A second go issues the new value.
- go pulsed at cycles 10 and 30 during busy: exactly one sequence and one update. go in the DONE cycle starts a new sequence whose first wr is 1 cycle later.
- rst asserted at cycle 20: outputs are 0 asynchronously, no update pulse ever, busy_o=0. The next go performs a full correct load.
- Writes to addresses 8, 15 and 25: no staging slot changes, and the replayed data matches prior contents.

Source files
------------

// File: rtl/biquad8_pole_coeff_loader_if.sv
// Host staging bus plus pole-FIR coefficient port of the biquad8 coefficient loader.
interface biquad8_pole_coeff_loader_if #(
  parameter int CBITS = 18
);
  logic [4:0]       host_adr_i;
  logic [CBITS-1:0] host_dat_i;
  logic             host_wr_i;
  logic             go_i;
  logic [4:0]       coeff_adr_o;
  logic             coeff_wr_o;
  logic [CBITS-1:0] coeff_dat_o;
  logic             coeff_update_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output host_adr_i, host_dat_i, host_wr_i, go_i,
    input  coeff_adr_o, coeff_wr_o, coeff_dat_o, coeff_update_o, busy_o, done_o
  );

  modport slave (
    input  host_adr_i, host_dat_i, host_wr_i, go_i,
    output coeff_adr_o, coeff_wr_o, coeff_dat_o, coeff_update_o, busy_o, done_o
  );
endinterface

// File: rtl/biquad8_pole_coeff_loader.sv
// Snapshots the staged pole coefficients on go and replays them into the B-cascade chains.
// First write 1 cycle after go capture, update at 1+HOLD*17, done next; go ignored while busy.
module biquad8_pole_coeff_loader #(
  parameter int FLEN  = 7,
  parameter int GLEN  = 8,
  parameter int CBITS = 18,
  parameter int HOLD  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  biquad8_pole_coeff_loader_if.slave  bus
);
  localparam int HW = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [4:0]    F_CROSS   = 5'(FLEN);
  localparam logic [4:0]    F_LAST    = 5'(FLEN - 1);
  localparam logic [4:0]    G_CROSS   = 5'(16 + GLEN);
  localparam logic [4:0]    G_LAST    = 5'(16 + GLEN - 1);
  localparam logic [4:0]    G_K0      = 5'(FLEN + 1);
  localparam logic [4:0]    SLOT_LAST = 5'(FLEN + GLEN + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WRITE, S_UPDATE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       slot_q, slot_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CBITS-1:0] stage_q [32];
  logic [CBITS-1:0] stage_d [32];
  logic [CBITS-1:0] work_q  [32];
  logic [CBITS-1:0] work_d  [32];
  logic [4:0]       coeff_adr_q, coeff_adr_d;
  logic [CBITS-1:0] coeff_dat_q, coeff_dat_d;
  logic             coeff_wr_q, coeff_wr_d;
  logic             coeff_update_q, coeff_update_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic adr_valid(input logic [4:0] a);
    return (a <= F_CROSS) || ((a >= 5'd16) && (a <= G_CROSS));
  endfunction

  // Cross DSPs go first: they load on any address >= their index, and the
  // junk they shift into the cascade is flushed by the full-length chain writes.
  function automatic logic [4:0] slot_adr(input logic [4:0] k);
    if (k == 5'd0)        return F_CROSS;
    else if (k < G_K0)    return F_LAST;
    else if (k == G_K0)   return G_CROSS;
    else                  return G_LAST;
  endfunction

  function automatic logic [4:0] slot_src(input logic [4:0] k);
    if (k == 5'd0)        return F_CROSS;
    else if (k < G_K0)    return F_CROSS - k;
    else if (k == G_K0)   return G_CROSS;
    else                  return G_CROSS - (k - G_K0);
  endfunction

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    hold_d         = hold_q;
    stage_d        = stage_q;
    work_d         = work_q;
    coeff_adr_d    = '0;
    coeff_dat_d    = '0;
    coeff_wr_d     = 1'b0;
    coeff_update_d = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;

    if (bus.host_wr_i && adr_valid(bus.host_adr_i)) begin
      stage_d[bus.host_adr_i] = bus.host_dat_i;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (bus.go_i) begin
          // Snapshot uses the pre-write staging contents of this cycle.
          work_d  = stage_q;
          busy_d  = 1'b1;
          slot_d  = '0;
          hold_d  = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        state_d     = S_WRITE;
        hold_d      = '0;
        coeff_wr_d  = 1'b1;
        coeff_adr_d = slot_adr(slot_q);
        coeff_dat_d = work_q[slot_src(slot_q)];
      end
      S_WRITE: begin
        if (hold_q == HOLD_LAST) begin
          if (slot_q == SLOT_LAST) begin
            coeff_update_d = 1'b1;
            state_d        = S_UPDATE;
          end else begin
            slot_d      = slot_q + 5'd1;
            hold_d      = '0;
            coeff_wr_d  = 1'b1;
            coeff_adr_d = slot_adr(slot_d);
            coeff_dat_d = work_q[slot_src(slot_d)];
          end
        end else begin
          hold_d      = hold_q + HW'(1);
          coeff_adr_d = coeff_adr_q;
          coeff_dat_d = coeff_dat_q;
        end
      end
      S_UPDATE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      slot_q         <= '0;
      hold_q         <= '0;
      coeff_adr_q    <= '0;
      coeff_dat_q    <= '0;
      coeff_wr_q     <= 1'b0;
      coeff_update_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        stage_q[i] <= '0;
        work_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      hold_q         <= hold_d;
      coeff_adr_q    <= coeff_adr_d;
      coeff_dat_q    <= coeff_dat_d;
      coeff_wr_q     <= coeff_wr_d;
      coeff_update_q <= coeff_update_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      for (int i = 0; i < 32; i++) begin
        stage_q[i] <= stage_d[i];
        work_q[i]  <= work_d[i];
      end
    end
  end

  assign bus.coeff_adr_o    = coeff_adr_q;
  assign bus.coeff_dat_o    = coeff_dat_q;
  assign bus.coeff_wr_o     = coeff_wr_q;
  assign bus.coeff_update_o = coeff_update_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// Scoreboard bench: driver pushes expected port events from a staging-bank model,
// a negedge monitor pops/compares them and feeds a model of the pole-FIR B1/B2 chains.
module tb_biquad8_pole_coeff_loader;
  localparam int FLEN  = 7;
  localparam int GLEN  = 8;
  localparam int CBITS = 18;
  localparam int HOLD  = 3;
  localparam int NWR   = FLEN + GLEN + 2;
  localparam int UPD   = 1 + HOLD * NWR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  biquad8_pole_coeff_loader_if #(.CBITS(CBITS)) bus();

  biquad8_pole_coeff_loader #(
    .FLEN(FLEN), .GLEN(GLEN), .CBITS(CBITS), .HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int               cyc;
    int               kind;   // 0 write, 1 update, 2 done
    logic [4:0]       adr;
    logic [CBITS-1:0] dat;
  } ev_t;

  ev_t              exp_q[$];
  logic [CBITS-1:0] snap_q[$];
  logic [CBITS-1:0] stage [32];
  logic [CBITS-1:0] b1 [32];
  logic [CBITS-1:0] b2 [32];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  act = 0;
  int  act_p = 0;
  bit  mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit slot_ok(input int a);
    return (a >= 0 && a <= FLEN) || (a >= 16 && a <= 16 + GLEN);
  endfunction

  // Expected replay: cross first, then each chain from its last slot downwards.
  task automatic start_seq(input int p);
    int   adrs[$];
    int   srcs[$];
    ev_t  e;
    act   = 1;
    act_p = p;
    adrs.push_back(FLEN); srcs.push_back(FLEN);
    for (int s = FLEN - 1; s >= 0; s--) begin adrs.push_back(FLEN - 1); srcs.push_back(s); end
    adrs.push_back(16 + GLEN); srcs.push_back(16 + GLEN);
    for (int s = 16 + GLEN - 1; s >= 16; s--) begin adrs.push_back(16 + GLEN - 1); srcs.push_back(s); end
    foreach (adrs[k]) begin
      e.cyc  = p + 1 + HOLD * k;
      e.kind = 0;
      e.adr  = 5'(adrs[k]);
      e.dat  = stage[srcs[k]];
      exp_q.push_back(e);
    end
    e.cyc = p + UPD;     e.kind = 1; e.adr = '0; e.dat = '0; exp_q.push_back(e);
    e.cyc = p + UPD + 1; e.kind = 2; exp_q.push_back(e);
    for (int s = 0; s < 32; s++) snap_q.push_back(stage[s]);
  endtask

  task automatic drive(input bit go, input bit wr, input int a, input logic [CBITS-1:0] d);
    bus.go_i       = go;
    bus.host_wr_i  = wr;
    bus.host_adr_i = 5'(a);
    bus.host_dat_i = d;
    if (go && !(act && (cyc + 1) <= act_p + UPD + 1)) start_seq(cyc + 1);
    if (wr && slot_ok(a)) stage[a] = d;
    @(posedge clk); #1;
    bus.go_i       = 1'b0;
    bus.host_wr_i  = 1'b0;
    bus.host_adr_i = '0;
    bus.host_dat_i = '0;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 5000) begin drive(0, 0, 0, '0); n++; end
  endtask

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act_v, exp_v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_coeff_wr",     32'(bus.coeff_wr_o),     0);
    chk("rst_coeff_adr",    32'(bus.coeff_adr_o),    0);
    chk("rst_coeff_dat",    32'(bus.coeff_dat_o),    0);
    chk("rst_coeff_update", 32'(bus.coeff_update_o), 0);
    chk("rst_busy",         32'(bus.busy_o),         0);
    chk("rst_done",         32'(bus.done_o),         0);
    exp_q.delete();
    snap_q.delete();
    act = 0;
    for (int s = 0; s < 32; s++) stage[s] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pole-FIR consumer: the addressed chain shifts every cascade DSP with index <= local addr;
  // the cross DSP loads directly when the local addr reaches its index.
  task automatic consumer_write(input logic [4:0] a, input logic [CBITS-1:0] d);
    int base = (a < 16) ? 0 : 16;
    int len  = (a < 16) ? FLEN : GLEN;
    int loc  = int'(a) - base;
    if (loc >= len) b1[base + len] = d;
    for (int i = len - 1; i >= 1; i--) if (loc >= i) b1[base + i] = b1[base + i - 1];
    b1[base] = d;
  endtask

  bit               wr_d1, wr_d2, busy_exp;
  logic [4:0]       adr_s, hold_adr;
  logic [CBITS-1:0] hold_dat;
  int               hold_left, akind, nact;
  ev_t              e;
  logic [CBITS-1:0] sv;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      wr_d1 = 0; wr_d2 = 0; hold_left = 0;
    end else begin
      busy_exp = act && (cyc >= act_p) && (cyc <= act_p + UPD);
      if (wr_d2) consumer_write(adr_s, bus.coeff_dat_o);
      if (wr_d1) adr_s = bus.coeff_adr_o;
      wr_d2 = wr_d1;
      wr_d1 = bus.coeff_wr_o;
      if (bus.coeff_update_o) for (int s = 0; s < 32; s++) b2[s] = b1[s];

      if (hold_left > 0) begin
        checks++;
        if (bus.coeff_adr_o !== hold_adr || bus.coeff_dat_o !== hold_dat) begin
          errors++;
          $display("FAIL hold cyc %0d: adr/dat %0d/%0h, required %0d/%0h", cyc, bus.coeff_adr_o, bus.coeff_dat_o, hold_adr, hold_dat);
        end
        hold_left--;
      end
      if (bus.coeff_wr_o) begin hold_adr = bus.coeff_adr_o; hold_dat = bus.coeff_dat_o; hold_left = HOLD - 1; end

      checks++;
      if (bus.busy_o !== busy_exp) begin
        errors++;
        $display("FAIL busy cyc %0d: got %0b, required %0b", cyc, bus.busy_o, busy_exp);
      end
      if (!busy_exp && !bus.done_o) begin
        checks++;
        if (bus.coeff_adr_o !== '0 || bus.coeff_dat_o !== '0 || bus.coeff_update_o !== 1'b0 || bus.coeff_wr_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero cyc %0d: wr/adr/dat/upd %0b/%0d/%0h/%0b, required all 0", cyc, bus.coeff_wr_o, bus.coeff_adr_o, bus.coeff_dat_o, bus.coeff_update_o);
        end
      end

      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missed_event kind %0d: not seen at cycle %0d, required at cycle %0d", e.kind, cyc, e.cyc);
        if (e.kind == 2) repeat (32) void'(snap_q.pop_front());
      end

      nact = int'(bus.coeff_wr_o) + int'(bus.coeff_update_o) + int'(bus.done_o);
      if (nact > 0) begin
        akind = bus.coeff_wr_o ? 0 : (bus.coeff_update_o ? 1 : 2);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc %0d: kind %0d adr %0d dat %0h, required none", cyc, akind, bus.coeff_adr_o, bus.coeff_dat_o);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.kind != akind || nact > 1 ||
              (akind == 0 && (bus.coeff_adr_o !== e.adr || bus.coeff_dat_o !== e.dat))) begin
            errors++;
            $display("FAIL event: got cyc %0d kind %0d adr %0d dat %0h (n=%0d), required cyc %0d kind %0d adr %0d dat %0h",
                     cyc, akind, bus.coeff_adr_o, bus.coeff_dat_o, nact, e.cyc, e.kind, e.adr, e.dat);
          end
          if (e.kind == 2) begin
            for (int s = 0; s < 32; s++) begin
              sv = snap_q.pop_front();
              if (slot_ok(s) && akind == 2) begin
                checks++;
                if (b2[s] !== sv) begin
                  errors++;
                  $display("FAIL b2_slot%0d: got %0h, required %0h", s, b2[s], sv);
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int n;
    bus.go_i = 0; bus.host_wr_i = 0; bus.host_adr_i = '0; bus.host_dat_i = '0;
    for (int s = 0; s < 32; s++) begin stage[s] = '0; b1[s] = '0; b2[s] = '0; end
    #2;
    do_reset();
    mon_en = 1;

    // Distinct values 0x100+s in every valid slot.
    for (int s = 0; s < 32; s++) if (slot_ok(s)) drive(0, 1, s, CBITS'(32'h100 + s));
    drive(1, 0, 0, '0);
    wait_cyc(act_p + 60);

    // Invalid addresses are dropped; the replay repeats the prior contents.
    drive(0, 1, 8,  CBITS'($urandom));
    drive(0, 1, 15, CBITS'($urandom));
    drive(0, 1, 25, CBITS'($urandom));
    drive(1, 0, 0, '0);
    wait_cyc(act_p + 60);

    // Write in the go cycle and during busy only affect the next load.
    drive(1, 1, 3, CBITS'(32'h3AB));
    for (int i = 0; i < 20; i++) drive(0, 1, $urandom_range(0, 24), CBITS'($urandom));
    wait_cyc(act_p + 60);
    drive(1, 0, 0, '0);
    wait_cyc(act_p + 60);

    // go at cycles 10 and 30 ignored; go in the DONE cycle accepted.
    drive(1, 0, 0, '0);
    p0 = act_p;
    wait_cyc(p0 + 9);  drive(1, 0, 0, '0);
    wait_cyc(p0 + 29); drive(1, 0, 0, '0);
    wait_cyc(p0 + UPD + 1); drive(1, 0, 0, '0);
    wait_cyc(act_p + 60);

    // Reset at cycle 20 of a load: no update, then a full reload works.
    for (int s = 0; s < 32; s++) if (slot_ok(s)) drive(0, 1, s, CBITS'($urandom));
    drive(1, 0, 0, '0);
    p0 = act_p;
    wait_cyc(p0 + 20);
    do_reset();
    wait_cyc(cyc + 60);
    for (int s = 0; s < 32; s++) if (slot_ok(s)) drive(0, 1, s, CBITS'($urandom));
    drive(1, 0, 0, '0);
    wait_cyc(act_p + 60);

    // Randomized staging traffic, stray go pulses and busy-time writes.
    repeat (6) begin
      n = $urandom_range(3, 20);
      for (int i = 0; i < n; i++)
        drive($urandom_range(0, 7) == 0, 1, $urandom_range(0, 31), CBITS'($urandom));
      drive(1, 0, 0, '0);
      for (int i = 0; i < 30; i++)
        drive($urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 31), CBITS'($urandom));
      wait_cyc(act_p + 60);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin drive(0, 0, 0, '0); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
